alu_md: RTL
===========

Name: alu_md

Overview:
- Registered, parametrised successor to the pipeline's single-cycle integer ALU.
- Keeps the existing base-ALU opcodes and adds RV32M/RV64M multiply, divide and remainder.
- Uses a valid/ready handshake so the execute stage can stall on the multi-cycle divider.
- Sits in the EX stage. Issue logic drives the in_* ports; the EX/MEM register consumes the out_* ports.

Parameters:
- XLEN, 32: operand/result width; must be 32 or 64.
- SHW, $clog2(XLEN): shift-amount width, derived; not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  5  operation code (see Behaviour).
- in_a  in  XLEN  operand A (rs1).
- in_b  in  XLEN  operand B (rs2/imm).
- flush  in  1  kill any in-flight operation (pipeline redirect).
- out_valid  out  1  result valid; one-cycle pulse per accepted op.
- out_result  out  XLEN  registered result.
- out_zero  out  1  registered (result == 0).

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset rst is synchronous and active-high.
  - Reset clears out_valid, out_result and out_zero to 0 and puts the FSM in IDLE.
  - In IDLE, in_ready = 1, including while rst is high.
  - Any input presented while rst = 1 is ignored.
- Opcodes, in_op[4] = 0 (base ops, 4-bit codes unchanged):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SLT, 6 SRL, 7 SRA, 8 XOR, 9 SLTU.
  - Codes 10-15 give result 0.
- Opcodes, in_op[4] = 1 (M-extension):
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
  - Codes 8-15 give result 0.
- Arithmetic rules:
  - Shifts use in_b[SHW-1:0].
  - SLT/SLTU return 1 or 0, zero-extended.
  - MUL returns the low XLEN bits of the 2*XLEN product.
  - MULH* return the high XLEN bits. Signedness: MULH s×s, MULHSU s(a)×u(b), MULHU u×u.
  - All arithmetic wraps modulo 2^XLEN.
- Handshake: an op is accepted at a rising edge where in_valid & in_ready & !flush & !rst.
- FSM states:
  - IDLE: in_ready = 1.
    - On accept of a single-cycle op (all base ops, MUL*, and the DIV/REM fast paths): compute, register the result, pulse out_valid the next cycle, stay in IDLE. Back-to-back issue gives one result per cycle.
    - On accept of DIV/DIVU/REM/REMU without a fast path: latch |a|, |b|, the sign flags and the op; clear the counter; go to DIV.
  - DIV: in_ready = 0.
    - One radix-2 restoring iteration per cycle, XLEN cycles; the counter runs 0..XLEN-1.
    - At count XLEN-1, go to FIX.
  - FIX: in_ready = 0.
    - Apply sign correction: quotient negated if sign(a) != sign(b); remainder takes sign(a).
    - Register the result, pulse out_valid, return to IDLE.
- Divider latency: acceptance edge E0 → result and out_valid visible after edge E(XLEN+1). in_ready reasserts in the same cycle out_valid is high.
- Divider fast paths (single-cycle, from IDLE):
  - Divide by zero: quotient = all ones; remainder = in_a.
  - Signed overflow (a = most-negative, b = -1): DIV returns in_a; REM returns 0.
- flush: in any state, at the next edge go to IDLE. No out_valid for the killed op. A same-cycle in_valid is not accepted.
- rst mid-divide: same as flush, plus the outputs are cleared.
- Output hold:
  - out_result and out_zero hold their last value until the next completion.
  - out_valid is low in every cycle with no completion.

Decomposition:
- Package alu_md_pkg holds:
  - the 4-bit base opcode localparams, identical to the existing ALU encoding;
  - the 5-bit M-op localparams;
  - the FSM state enum (IDLE, DIV, FIX).
- Sub-module div_iter (parameter XLEN) holds:
  - the unsigned restoring-division datapath: remainder/quotient shift registers and the per-cycle subtract-compare;
  - ports: clk, rst, load, step, dividend, divisor, quotient, remainder.
- Top level owns: the FSM, the combinational base ops and multiplier, the fast paths, and sign fix-up.

Test Plan:
- XLEN = 32; ADD a = 0xFFFFFFFF, b = 1 → out_valid next cycle, result 0, out_zero = 1. Then SRA a = 0x80000000, b = 0x24 → 0xF8000000 (shift 4).
- Back-to-back MUL 7×-3, MULH 0x80000000×0x80000000, MULHU 0xFFFFFFFF×0xFFFFFFFF → results 0xFFFFFFEB, 0x40000000, 0xFFFFFFFE on three consecutive cycles; in_ready stays 1.
- DIV -7/2 then REM -7/2:
  - first result -3 (0xFFFFFFFD); out_valid exactly 33 edges after accept;
  - in_ready low for 33 cycles;
  - second result -1.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. DIV 0x80000000/-1 → 0x80000000; REM → 0. Each completes in 1 cycle.
- flush asserted 10 cycles into a DIV:
  - FSM back in IDLE next cycle, in_ready = 1, no out_valid for the killed op;
  - a following ADD 2+3 returns 5.
- rst pulsed mid-DIV → out_valid/out_result/out_zero = 0 and in_ready = 1 the cycle after; an op with in_valid high during rst produces no result.

Source files
------------

// File: rtl/alu_md_pkg.sv
// rtl/alu_md_pkg.sv - opcode encodings and FSM states shared by the alu_md block
package alu_md_pkg;

    // Base ALU opcodes (in_op[4] = 0), same encoding as the single-cycle ALU
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    // M-extension opcodes (in_op[4] = 1)
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_md_div_iter.sv
// rtl/alu_md_div_iter.sv - unsigned radix-2 restoring divider datapath, one bit per step
// Ports: clk, rst (sync, active-high); load latches dividend/divisor and clears the
// partial remainder; step performs one shift/subtract iteration; quotient and remainder
// are final after XLEN steps.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [XLEN-1:0] dsr;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while new quotient bits enter at the LSB.
    assign shifted = {remainder, quotient[XLEN-1]};
    assign diff    = shifted - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            dsr       <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dsr       <= divisor;
        end else if (step) begin
            if (!diff[XLEN]) begin
                remainder <= diff[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end else begin
                remainder <= shifted[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// rtl/alu_md.sv - registered EX-stage ALU with RV32M/RV64M multiply/divide and valid/ready
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_op/in_a/in_b issue side;
// flush kills any in-flight op; out_valid (one-cycle pulse), out_result, out_zero registered.
module alu_md
    import alu_md_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero
);

    state_t state, state_nxt;

    logic [SHW-1:0]    count;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   base_res;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0]   op_res;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN-1:0]   fast_res, fix_res;
    logic [XLEN-1:0]   div_q, div_r;
    logic              div_signed, is_divop, is_remop, b_zero, ovf, slow;
    logic              accept, load, step, fix_done;
    logic              neg_q, neg_r, rem_sel;

    assign shamt = in_b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (in_op[3:0])
            OP_ADD:  base_res = in_a + in_b;
            OP_SUB:  base_res = in_a - in_b;
            OP_AND:  base_res = in_a & in_b;
            OP_OR:   base_res = in_a | in_b;
            OP_SLL:  base_res = in_a << shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OP_SRL:  base_res = in_a >> shamt;
            OP_SRA:  base_res = $signed(in_a) >>> shamt;
            OP_XOR:  base_res = in_a ^ in_b;
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, in_a < in_b};
            default: base_res = '0;
        endcase
    end

    // Sign- or zero-extend to 2*XLEN so one unsigned multiplier yields all four products.
    always_comb begin
        mul_a = {{XLEN{1'b0}}, in_a};
        mul_b = {{XLEN{1'b0}}, in_b};
        if (in_op == OP_MULH || in_op == OP_MULHSU)
            mul_a = {{XLEN{in_a[XLEN-1]}}, in_a};
        if (in_op == OP_MULH)
            mul_b = {{XLEN{in_b[XLEN-1]}}, in_b};
    end

    assign prod = mul_a * mul_b;

    assign div_signed = (in_op == OP_DIV) || (in_op == OP_REM);
    assign is_remop   = (in_op == OP_REM) || (in_op == OP_REMU);
    assign is_divop   = (in_op == OP_DIV) || (in_op == OP_DIVU) || is_remop;
    assign b_zero     = (in_b == '0);
    assign ovf        = div_signed && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    assign slow       = is_divop && !b_zero && !ovf;

    // Divide-by-zero and signed overflow have fixed architectural results.
    assign fast_res = b_zero ? (is_remop ? in_a : '1) : (is_remop ? '0 : in_a);

    assign abs_a = (div_signed && in_a[XLEN-1]) ? -in_a : in_a;
    assign abs_b = (div_signed && in_b[XLEN-1]) ? -in_b : in_b;

    always_comb begin
        op_res = base_res;
        if (in_op[4]) begin
            case (in_op)
                OP_MUL:                         op_res = prod[XLEN-1:0];
                OP_MULH, OP_MULHSU, OP_MULHU:   op_res = prod[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU, OP_REM, OP_REMU: op_res = fast_res;
                default:                        op_res = '0;
            endcase
        end
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign fix_res = rem_sel ? (neg_r ? -div_r : div_r)
                             : (neg_q ? -div_q : div_q);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        accept    = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        fix_done  = 1'b0;
        case (state)
            IDLE: begin
                accept = in_valid && !flush && !rst;
                if (accept && slow) begin
                    load      = 1'b1;
                    state_nxt = DIV;
                end
            end
            DIV: begin
                step = 1'b1;
                if (count == SHW'(XLEN-1)) state_nxt = FIX;
            end
            FIX: begin
                fix_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
            fix_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            rem_sel    <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (load) begin
                count   <= '0;
                neg_q   <= div_signed && (in_a[XLEN-1] ^ in_b[XLEN-1]);
                neg_r   <= div_signed && in_a[XLEN-1];
                rem_sel <= is_remop;
            end else if (step) begin
                count <= count + SHW'(1);
            end
            if (accept && !slow) begin
                out_valid  <= 1'b1;
                out_result <= op_res;
                out_zero   <= (op_res == '0);
            end else if (fix_done) begin
                out_valid  <= 1'b1;
                out_result <= fix_res;
                out_zero   <= (fix_res == '0);
            end
        end
    end

endmodule
